// File: rtl/mesh_2x2_sequencer_pkg.sv
// Shared definitions for the 2x2 systolic mesh sequencer: FSM state codes,
// default field widths and the MAC index map used for enable vectors.
package mesh_2x2_sequencer_pkg;

   localparam int DW_DEFAULT = 4;
   localparam int KW_DEFAULT = 4;

   localparam int ST_W = 3;
   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_CLEAR = 3'd1;
   localparam logic [ST_W-1:0] ST_FEED  = 3'd2;
   localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
   localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

   // Bit positions in ENa/ENr: row-major MAC numbering of the mesh.
   localparam int MAC00 = 0;
   localparam int MAC01 = 1;
   localparam int MAC10 = 2;
   localparam int MAC11 = 3;

endpackage

// File: rtl/mesh_2x2_sequencer_skew.sv
// mesh_skew_pipe: turns accepted beats into the diagonally skewed mesh
// enables. A beat reaches MAC00 immediately, MAC01/MAC10 one cycle later
// through the Rp/Rq skew registers, and MAC11 two cycles later. The last
// beat is tracked one stage further so each result register loads just
// after its MAC has taken its final product.
module mesh_skew_pipe
   import mesh_2x2_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       beat,
   input  logic       last,
   output logic       en_p,
   output logic       en_q,
   output logic [3:0] en_a,
   output logic [3:0] en_r,
   output logic       pipe_busy
);

   logic v1_q, v1_d, v2_q, v2_d;
   logic l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;

   // Next values of the valid and last-beat delay lines.
   always_comb begin
      v1_d = beat;
      v2_d = v1_q;
      l1_d = beat & last;
      l2_d = l1_q;
      l3_d = l2_q;
   end

   // Delay-line registers; a reset drops any in-flight beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         l1_q <= 1'b0;
         l2_q <= 1'b0;
         l3_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         l1_q <= l1_d;
         l2_q <= l2_d;
         l3_q <= l3_d;
      end
   end

   // Map pipe stages onto skew-register, accumulate and result enables.
   always_comb begin
      en_p        = beat;
      en_q        = v1_q;
      en_a        = 4'b0000;
      en_a[MAC00] = beat;
      en_a[MAC01] = v1_q;
      en_a[MAC10] = v1_q;
      en_a[MAC11] = v2_q;
      en_r        = 4'b0000;
      en_r[MAC00] = l1_q;
      en_r[MAC01] = l2_q;
      en_r[MAC10] = l2_q;
      en_r[MAC11] = l3_q;
      pipe_busy   = v1_q | v2_q;
   end

endmodule

// File: rtl/mesh_2x2_sequencer.sv
// mesh_2x2_sequencer: accepts a matrix-multiply job (K, then K coefficient
// slices), clears the 2x2 mesh, streams the slices in with skewed enables
// and pulses DONE once C = A x B is stable on the mesh outputs.
module mesh_2x2_sequencer
   import mesh_2x2_sequencer_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int KW = KW_DEFAULT
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [KW-1:0] K_LEN,
   output logic          BUSY,
   output logic          DONE,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [DW-1:0] IN_A0,
   input  logic [DW-1:0] IN_A1,
   input  logic [DW-1:0] IN_B0,
   input  logic [DW-1:0] IN_B1,
   output logic          MESH_RST,
   output logic [DW-1:0] A00,
   output logic [DW-1:0] A10,
   output logic [DW-1:0] B00,
   output logic [DW-1:0] B01,
   output logic          ENp,
   output logic          ENq,
   output logic [3:0]    ENa,
   output logic [3:0]    ENr
);

   logic [ST_W-1:0] state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [KW:0]     beats_q, beats_d;
   logic [KW:0]     beats_inc;
   logic            in_feed;
   logic            beat;
   logic            last;
   logic            pipe_busy;
   logic            drain_done;

   // Handshake, beat detection and the mesh-facing datapath outputs.
   // The beat counter is one bit wider than K so K = 2^KW-1 never wraps.
   always_comb begin
      in_feed    = (state_q == ST_FEED);
      beats_inc  = beats_q + (KW+1)'(1);
      IN_READY   = in_feed && (beats_q < {1'b0, k_q});
      beat       = IN_VALID & IN_READY;
      last       = beat & (beats_inc == {1'b0, k_q});
      drain_done = ENr[MAC11] & ~pipe_busy;
      BUSY       = (state_q != ST_IDLE);
      DONE       = (state_q == ST_DONE);
      MESH_RST   = (state_q != ST_CLEAR);
      A00        = in_feed ? IN_A0 : '0;
      A10        = in_feed ? IN_A1 : '0;
      B00        = in_feed ? IN_B0 : '0;
      B01        = in_feed ? IN_B1 : '0;
   end

   // Job FSM: IDLE -> CLEAR -> FEED -> DRAIN -> DONE, with K = 0 skipping
   // straight from CLEAR to DONE.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      beats_d = beats_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               k_d     = K_LEN;
               beats_d = '0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            state_d = (k_q != '0) ? ST_FEED : ST_DONE;
         end
         ST_FEED: begin
            if (beat) begin
               beats_d = beats_inc;
               if (last) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched K and beat counter; reset abandons any job in flight.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         beats_q <= beats_d;
      end
   end

   mesh_skew_pipe u_skew (
      .clk       (CLK),
      .rst_n     (RST),
      .beat      (beat),
      .last      (last),
      .en_p      (ENp),
      .en_q      (ENq),
      .en_a      (ENa),
      .en_r      (ENr),
      .pipe_busy (pipe_busy)
   );

endmodule

// File: doc/mesh_2x2_sequencer.md
Name: mesh_2x2_sequencer

Overview:
Sequencer for the 2x2 systolic matrix-multiply mesh (4 MACs, with Rp/Rq skew registers feeding MAC01/MAC10/MAC11).
- Accepts a job: inner dimension K, then K coefficient slices {A[0][k], A[1][k], B[k][0], B[k][1]} over a valid/ready stream.
- Clears the mesh, drives the slices into it, and generates every mesh enable (ENp, ENq, ENa, ENr) with the correct diagonal skew.
- Pulses DONE when C = A×B is stable on MTX00..MTX11.
- Sits between the coefficient source (memory/DMA front end) and the mesh instance.

Parameters:
DW, 4, coefficient width (matches mesh 4-bit inputs)
KW, 4, width of K length field; K range 0..2^KW-1

Ports:
CLK  in  1  master clock, rising edge
RST  in  1  master reset, asynchronous, active-low
START  in  1  job request; sampled in IDLE only
K_LEN  in  KW  inner dimension; latched on accepted START
BUSY  out  1  high from accepted START until DONE cycle inclusive
DONE  out  1  one-cycle pulse, results valid on mesh outputs
IN_VALID  in  1  slice valid
IN_READY  out  1  sequencer accepts slice (beat = IN_VALID & IN_READY)
IN_A0, IN_A1  in  DW  A[0][k], A[1][k]
IN_B0, IN_B1  in  DW  B[k][0], B[k][1]
MESH_RST  out  1  active-low clear to mesh (clears accumulators and skew regs)
A00, A10, B00, B01  out  DW  mesh coefficient inputs
ENp, ENq  out  1  skew-register enables
ENa  out  4  MAC accumulate enables, bit i = MAC i (00,01,10,11)
ENr  out  4  MAC result-register load enables

Behaviour:
Reset (RST low, any time, incl. mid-job): state=IDLE; all enables 0, BUSY=0, DONE=0, IN_READY=0, MESH_RST=1, coefficient outputs 0, counters and valid pipes 0. Partially computed results are discarded.
FSM states:
- IDLE: START=1 → latch K_LEN into k_reg, BUSY=1 → CLEAR.
- CLEAR: exactly 1 cycle, MESH_RST=0 → FEED if k_reg>0, else → DONE.
- FEED: IN_READY=1 while beats_accepted<k_reg. On the k_reg-th beat → DRAIN. IN_VALID low inserts a bubble; no enable fires for that slot.
- DRAIN: IN_READY=0; wait until valid pipe empty and ENr[3] issued → DONE.
- DONE: DONE=1 for one cycle, BUSY still 1 → IDLE.
Datapath timing:
- A00=IN_A0, A10=IN_A1, B00=IN_B0, B01=IN_B1 combinationally in FEED; 0 otherwise.
- Valid pipe v0 = beat (combinational), v1 = reg(v0), v2 = reg(v1). Last-beat pipe l0/l1/l2/l3 built the same way from beat & last.
- For a beat accepted in cycle t:
  - ENp=1 and ENa[0]=1 at t
  - ENq=1, ENa[1]=1, ENa[2]=1 at t+1
  - ENa[3]=1 at t+2
- For the last beat at t_L:
  - ENr[0] at t_L+1
  - ENr[1], ENr[2] at t_L+2
  - ENr[3] at t_L+3
  - DONE at t_L+4
- Bubbles only shift later beats. ENp/ENq never fire without a valid beat, so skew registers hold.
- No-bubble latency: START accepted at cycle 0 gives DONE at cycle K+5.
Boundaries:
- K=0: CLEAR → DONE; no ENa/ENr pulses; results stay 0 after the clear.
- START while BUSY: ignored; no queuing.
- IN_VALID outside FEED: ignored, IN_READY=0.
- Beat counter is KW+1 bits, so K=2^KW-1 causes no wrap.
Arithmetic widths are owned by the mesh: 4b×4b products, 8b accumulate, overflow wraps mod 256.

Decomposition:
- Shared package: state encoding (IDLE, CLEAR, FEED, DRAIN, DONE), DW/KW defaults, MAC index constants (MAC00=0, MAC01=1, MAC10=2, MAC11=3).
- One natural sub-module, mesh_skew_pipe: 3-stage valid pipe plus 4-stage last pipe producing ENp/ENq/ENa/ENr from beat/last.
- FSM and counter stay in the top.

Test Plan:
1. K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], no bubbles, sequencer+mesh → MTX00=19, MTX01=22, MTX10=43, MTX11=50 at DONE; DONE at cycle 7 after START.
2. Same job with IN_VALID low 2 cycles between beats → identical results; DONE delayed by exactly 2 cycles; ENa popcount per MAC = 2.
3. K=0 → MESH_RST low 1 cycle, DONE 2 cycles after START, all MTX=0, no ENa/ENr asserted.
4. START pulsed during FEED of a K=3 job → ignored; K not relatched, single DONE.
5. RST low mid-FEED (after beat 1 of 3), then new K=1 job with A=[[15],[15]], B=[[15,15]] → all MTX=225; no stale accumulation.
6. K=15, all coefficients 15 → 15×225 = 3375 mod 256 = 47 on all MTX; beat counter reaches 15 without wrap.
